// File: rtl/tone_frequency_meter_pkg.sv
// Shared defaults and state encodings for the tone frequency meter and its divider.
`timescale 1ns/1ps
package tone_frequency_meter_pkg;

    localparam int unsigned DEFAULT_ACCUMULATOR_BITS = 24;
    localparam int unsigned DEFAULT_FREQ_BITS        = 16;
    localparam int unsigned DEFAULT_PERIOD_BITS      = 24;

    typedef enum logic {
        StUnarmed,
        StArmed
    } meas_state_e;

    typedef enum logic [1:0] {
        StDivIdle,
        StDivRun,
        StDivDone
    } div_state_e;

endpackage

// File: rtl/tone_freq_divider.sv
// Iterative restoring divider, one quotient bit per cycle. The first bit is
// resolved in the same cycle the operands are loaded.
`timescale 1ns/1ps
module tone_freq_divider
    import tone_frequency_meter_pkg::*;
#(
    parameter int unsigned DIVIDEND_BITS = DEFAULT_ACCUMULATOR_BITS + 1,
    parameter int unsigned DIVISOR_BITS  = DEFAULT_PERIOD_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DIVIDEND_BITS-1:0] dividend,
    input  logic [DIVISOR_BITS-1:0]  divisor,
    output logic                     busy,
    output logic                     done,
    output logic [DIVIDEND_BITS-1:0] quotient
);

    localparam int unsigned CountBits = $clog2(DIVIDEND_BITS + 1);

    div_state_e                 state_q, state_d;
    logic [CountBits-1:0]       cnt_q, cnt_d;
    logic [DIVIDEND_BITS-1:0]   dvd_q, dvd_d;
    logic [DIVISOR_BITS-1:0]    rem_q, rem_d;
    logic [DIVISOR_BITS-1:0]    dsr_q, dsr_d;

    logic                       load;
    logic [DIVISOR_BITS-1:0]    src_rem, src_dsr, diff_lo, step_rem;
    logic [DIVIDEND_BITS-1:0]   src_dvd, step_dvd;
    logic [DIVISOR_BITS:0]      trial;
    logic                       ge;

    // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
    always_comb begin
        load     = start && (state_q == StDivIdle);
        src_rem  = load ? '0 : rem_q;
        src_dvd  = load ? dividend : dvd_q;
        src_dsr  = load ? divisor : dsr_q;
        trial    = {src_rem, src_dvd[DIVIDEND_BITS-1]};
        ge       = trial >= {1'b0, src_dsr};
        diff_lo  = trial[DIVISOR_BITS-1:0] - src_dsr;
        step_rem = ge ? diff_lo : trial[DIVISOR_BITS-1:0];
        step_dvd = {src_dvd[DIVIDEND_BITS-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        case (state_q)
            StDivIdle: begin
                if (load) begin
                    state_d = StDivRun;
                    cnt_d   = CountBits'(DIVIDEND_BITS - 1);
                    dvd_d   = step_dvd;
                    rem_d   = step_rem;
                    dsr_d   = divisor;
                end
            end
            StDivRun: begin
                dvd_d = step_dvd;
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CountBits'(1)) begin
                    state_d = StDivDone;
                end
            end
            default: state_d = StDivIdle;
        endcase
        if (abort) begin
            state_d = StDivIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StDivIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
        end
    end

    assign busy     = (state_q != StDivIdle);
    assign done     = (state_q == StDivDone);
    assign quotient = dvd_q;

endmodule

// File: rtl/tone_frequency_meter.sv
// Measures the period of an oscillator accumulator MSB and converts it back
// into the equivalent tone frequency word, round(2^ACCUMULATOR_BITS / period).
`timescale 1ns/1ps
module tone_frequency_meter
    import tone_frequency_meter_pkg::*;
#(
    parameter int unsigned ACCUMULATOR_BITS = DEFAULT_ACCUMULATOR_BITS,
    parameter int unsigned FREQ_BITS        = DEFAULT_FREQ_BITS,
    parameter int unsigned PERIOD_BITS      = DEFAULT_PERIOD_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   osc_msb,
    output logic [FREQ_BITS-1:0]   freq_word,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   valid,
    output logic                   saturated,
    output logic                   timeout,
    output logic                   dropped
);

    localparam int unsigned            DivBits      = ACCUMULATOR_BITS + 1;
    localparam logic [DivBits-1:0]     DividendBase = DivBits'(1) << ACCUMULATOR_BITS;
    localparam logic [PERIOD_BITS-1:0] CountMax     = '1;

    meas_state_e              state_q, state_d;
    logic                     msb_q;
    logic [PERIOD_BITS-1:0]   cnt_q, cnt_d;
    logic [PERIOD_BITS-1:0]   cap_q, cap_d;
    logic [FREQ_BITS-1:0]     freq_q, freq_d;
    logic [PERIOD_BITS-1:0]   period_q, period_d;
    logic                     sat_q, sat_d;
    logic                     timeout_q, timeout_d;
    logic                     valid_q, valid_d;
    logic                     dropped_q, dropped_d;

    logic                     rise, launch, accept, q_sat;
    logic                     div_busy, div_done;
    logic [DivBits-1:0]       dividend, quotient;

    assign rise     = osc_msb & ~msb_q;
    assign launch   = en && (state_q == StArmed) && rise && !div_busy;
    // Adding half the divisor turns the truncating divide into round-to-nearest.
    assign dividend = DividendBase + DivBits'(cnt_q >> 1);
    assign accept   = div_done && en;
    assign q_sat    = |quotient[DivBits-1:FREQ_BITS];

    tone_freq_divider #(
        .DIVIDEND_BITS (DivBits),
        .DIVISOR_BITS  (PERIOD_BITS)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (launch),
        .abort    (~en),
        .dividend (dividend),
        .divisor  (cnt_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        freq_d    = freq_q;
        period_d  = period_q;
        sat_d     = sat_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        dropped_d = 1'b0;

        if (accept) begin
            valid_d   = 1'b1;
            freq_d    = q_sat ? '1 : quotient[FREQ_BITS-1:0];
            sat_d     = q_sat;
            period_d  = cap_q;
            timeout_d = 1'b0;
        end

        if (!en) begin
            state_d = StUnarmed;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StUnarmed: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d   = StArmed;
                        cnt_d     = PERIOD_BITS'(1);
                        timeout_d = 1'b0;
                    end
                end
                default: begin
                    if (rise) begin
                        cnt_d = PERIOD_BITS'(1);
                        if (div_busy) begin
                            dropped_d = 1'b1;
                        end else begin
                            cap_d = cnt_q;
                        end
                    end else if (cnt_q == CountMax) begin
                        freq_d    = '0;
                        period_d  = '1;
                        sat_d     = 1'b0;
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                        state_d   = StUnarmed;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StUnarmed;
            msb_q     <= 1'b0;
            cnt_q     <= '0;
            cap_q     <= '0;
            freq_q    <= '0;
            period_q  <= '0;
            sat_q     <= 1'b0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            msb_q     <= osc_msb;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            freq_q    <= freq_d;
            period_q  <= period_d;
            sat_q     <= sat_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign freq_word = freq_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign saturated = sat_q;
    assign timeout   = timeout_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_tone_frequency_meter.sv
// Directed bench for tone_frequency_meter using a reduced configuration
// (16-bit accumulator, 12-bit frequency word, 12-bit period counter).
`timescale 1ns/1ps
module tb_tone_frequency_meter;

    localparam int unsigned ACC = 16;
    localparam int unsigned FW  = 12;
    localparam int unsigned PW  = 12;

    logic          clk = 1'b0;
    logic          rst, en, osc_msb;
    logic [FW-1:0] freq_word;
    logic [PW-1:0] period;
    logic          valid, saturated, timeout, dropped;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            nvalid, ndrop, phase, lat;
    logic [31:0]   last_freq, last_period;
    logic          last_sat, last_to;

    tone_frequency_meter #(
        .ACCUMULATOR_BITS (ACC),
        .FREQ_BITS        (FW),
        .PERIOD_BITS      (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .osc_msb   (osc_msb),
        .freq_word (freq_word),
        .period    (period),
        .valid     (valid),
        .saturated (saturated),
        .timeout   (timeout),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        nvalid = 0;
        ndrop  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (valid) begin
            nvalid++;
            last_freq   = 32'(freq_word);
            last_period = 32'(period);
            last_sat    = saturated;
            last_to     = timeout;
        end
        if (dropped) ndrop++;
    endtask

    // One-cycle-high pulse every p cycles; phase carries over between calls.
    task automatic run_train(input int p, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            osc_msb = (phase == 0);
            tick();
            phase = (phase + 1) % p;
        end
        osc_msb = 1'b0;
    endtask

    task automatic idle(input int ncyc);
        osc_msb = 1'b0;
        for (int c = 0; c < ncyc; c++) tick();
    endtask

    task automatic disarm();
        en = 1'b0;
        idle(2);
        en = 1'b1;
        phase = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; osc_msb = 1'b0; phase = 0;
        last_freq = '0; last_period = '0; last_sat = 1'b0; last_to = 1'b0;
        clear_tally();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("reset freq_word", 32'(freq_word), 32'h0);
        check("reset period",    32'(period),    32'h0);
        check("reset valid",     32'(valid),     32'h0);
        check("reset saturated", 32'(saturated), 32'h0);
        check("reset timeout",   32'(timeout),   32'h0);
        check("reset dropped",   32'(dropped),   32'h0);

        // Period 100: first rise only arms; 65586/100 -> 655.
        en = 1'b1;
        clear_tally(); run_train(100, 100);
        check("p100 arm no valid", 32'(nvalid), 32'd0);
        clear_tally(); run_train(100, 500);
        check("p100 valid count", 32'(nvalid), 32'd5);
        check("p100 freq",        last_freq,   32'd655);
        check("p100 period",      last_period, 32'd100);
        check("p100 sat",         32'(last_sat), 32'd0);
        check("p100 no drops",    32'(ndrop),  32'd0);

        // Rounding: 65536/33 = 1985.94 -> 1986; 65536/17 = 3855.06 -> 3855.
        phase = 0; clear_tally(); run_train(33, 330);
        check("p33 freq",   last_freq,   32'd1986);
        check("p33 period", last_period, 32'd33);
        phase = 0; clear_tally(); run_train(17, 170);
        check("p17 freq",   last_freq,     32'd3855);
        check("p17 sat",    32'(last_sat), 32'd0);

        // Period 10 is shorter than the divider latency: drops alternate with results.
        phase = 0; clear_tally(); run_train(10, 200);
        check("p10 freq",      last_freq,     32'hFFF);
        check("p10 sat",       32'(last_sat), 32'd1);
        check("p10 period",    last_period,   32'd10);
        check("p10 drops",     32'(ndrop >= 5), 32'd1);
        check("p10 alternate", 32'((nvalid - ndrop) <= 1 && (ndrop - nvalid) <= 1), 32'd1);

        // Fastest possible rise rate: 65537/2 = 32768 saturates.
        phase = 0; clear_tally(); run_train(2, 60);
        check("p2 freq",   last_freq,     32'hFFF);
        check("p2 sat",    32'(last_sat), 32'd1);
        check("p2 period", last_period,   32'd2);

        // Latency from the cycle that sees the closing rise to valid: ACC+2.
        disarm();
        run_train(40, 40);
        osc_msb = 1'b1;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            osc_msb = 1'b0;
            if (valid && lat == 0) begin
                lat = n;
                last_freq = 32'(freq_word);
            end
        end
        check("latency",     32'(lat),  32'(ACC + 2));
        check("p40 freq",    last_freq, 32'd1638);

        // Timeout: arm, then no edge for 4095 cycles.
        disarm();
        clear_tally(); run_train(5000, 4200);
        check("timeout valid count", 32'(nvalid),   32'd1);
        check("timeout freq",        last_freq,     32'h0);
        check("timeout period",      last_period,   32'hFFF);
        check("timeout flag",        32'(last_to),  32'd1);
        check("timeout level",       32'(timeout),  32'd1);
        phase = 0; clear_tally(); run_train(50, 1);
        check("timeout cleared", 32'(timeout), 32'd0);
        run_train(50, 99);
        check("post-timeout valid", 32'(nvalid), 32'd1);
        check("post-timeout freq",  last_freq,   32'd1311);
        check("post-timeout period", last_period, 32'd50);

        // en dropped five cycles into a division.
        disarm();
        clear_tally();
        run_train(30, 30);
        run_train(30, 6);
        en = 1'b0; idle(2); en = 1'b1;
        idle(40);
        check("en abort no valid", 32'(nvalid), 32'd0);
        phase = 0; run_train(30, 30);
        check("en rearm no valid", 32'(nvalid), 32'd0);
        run_train(30, 30);
        check("en rearm valid", 32'(nvalid), 32'd1);
        check("en rearm freq",  last_freq,   32'd2185);

        // rst five cycles into a division.
        disarm();
        clear_tally();
        run_train(30, 30);
        run_train(30, 6);
        rst = 1'b1; idle(1); rst = 1'b0;
        idle(40);
        check("rst abort no valid", 32'(nvalid),    32'd0);
        check("rst freq cleared",   32'(freq_word), 32'h0);
        phase = 0; run_train(30, 30);
        check("rst rearm no valid", 32'(nvalid), 32'd0);
        run_train(30, 30);
        check("rst rearm valid",  32'(nvalid),  32'd1);
        check("rst rearm period", last_period,  32'd30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
